vram_write_arbiter: RTL and testbench
=====================================

Name: vram_write_arbiter

Overview:
- Shares the two scanline VRAM write ports (even bank, odd bank) between two pixel producers: req0 (background fill) and req1 (overlay/sprite engine).
- Latches the active render bank at each line start and routes every granted write to that bank only; the bank being scanned out is never written.
- Counts writes per line and flags under-filled lines and out-of-range addresses.
- Sits between the pixel producers and the even/odd line-buffer RAMs that the video scan-out reads.

Parameters:
- ADDR_WIDTH, 10, line-buffer address width.
- DATA_WIDTH, 8, pixel data width.
- LINE_PIXELS, 800, valid addresses are 0..LINE_PIXELS-1; also the expected writes per line.
- CNT_WIDTH, $clog2(LINE_PIXELS+1), width of the per-line write counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- line_start  in  1  one-cycle pulse: a new render line begins
- render_odd  in  1  bank for the new line (1=odd, 0=even); sampled only when line_start=1
- req0_valid  in  1  background write request
- req0_ready  out  1  background write accepted this cycle
- req0_addr  in  ADDR_WIDTH  background pixel address
- req0_data  in  DATA_WIDTH  background pixel value
- req1_valid, req1_ready, req1_addr, req1_data  same as req0, overlay requester
- vram_even_we  out  1  even-bank write enable
- vram_even_addr  out  ADDR_WIDTH  even-bank address
- vram_even_d  out  DATA_WIDTH  even-bank write data
- vram_odd_we, vram_odd_addr, vram_odd_d  same for odd bank
- write_count  out  CNT_WIDTH  writes committed in the current line
- underrun  out  1  one-cycle pulse: previous line ended with write_count < LINE_PIXELS
- addr_err  out  1  sticky: a write with addr >= LINE_PIXELS was dropped; cleared only by reset

Behaviour:
- Reset values (async, rst_n=0):
  - state=IDLE, bank=0, rr_last=1 (so req0 wins the first tie).
  - All we=0; all addr and d outputs=0; write_count=0; underrun=0; addr_err=0.
- FSM states:
  - IDLE: both readies=0. On line_start: latch bank<=render_odd, go to ACTIVE; no underrun pulse.
  - ACTIVE: arbitration enabled. On line_start:
    - bank<=render_odd, write_count<=0.
    - underrun<=1 for one cycle if the old count < LINE_PIXELS.
    - Stay in ACTIVE.
- Ready rules (combinational from state, valids, line_start and rr_last):
  - No ready is asserted in IDLE or in any cycle where line_start=1 (the bank-switch cycle).
  - Only one requester valid: it gets ready.
  - Both valid: the requester not equal to rr_last gets ready.
  - rr_last updates to the granted index on every transfer.
  - At most one ready high per cycle.
- Transfer = valid && ready.
  - Addr < LINE_PIXELS: on the next clock, exactly one we (selected by the latched bank) = 1, with registered addr and data. The other bank's we = 0 and its addr/d hold. write_count increments, saturating at 2^CNT_WIDTH-1.
  - Addr >= LINE_PIXELS: the write is consumed (ready still asserted) but not issued. addr_err<=1; write_count unchanged.
- Latency: exactly 1 cycle from transfer to the we pulse. Sustained throughput is one write per cycle.
- Non-transfer cycles: both we=0. addr and d hold their last values.
- A transfer accepted in the cycle before line_start commits to the old bank, because its we pulse coincides with the line_start cycle.
- Valid, addr and data are not required to be stable without ready; a requester may drop valid at any time.
- Reset mid-line: outputs clear immediately (async). The FSM returns to IDLE and waits for the next line_start; the partial line is discarded silently (no underrun pulse).

Test Plan:
- Reset, then line_start with render_odd=0, then req0 streams addr 0..799 with data=addr[7:0] → vram_even_we high 800 consecutive cycles, each starting 1 cycle after its transfer; vram_odd_we stays 0; write_count=800; next line_start gives underrun=0.
- Both requesters valid continuously for 6 cycles in ACTIVE after reset → grants alternate req0,req1,req0,req1,req0,req1; the odd bank receives the writes when render_odd=1.
- req1 valid across a line_start pulse (render_odd changing 0→1) → both readies=0 in the line_start cycle; the transfer one cycle earlier lands on the even bank; the next transfer lands on the odd bank; write_count returns to 0.
- Line with only 500 writes, then line_start → underrun pulses high for exactly 1 cycle; write_count=0 after the pulse.
- req0 write to addr 800 → ready=1; no we on either bank; addr_err=1 and stays 1 through later line_starts until rst_n=0.
- rst_n asserted mid-stream at write 300 → all outputs 0 asynchronously; after release, requests ignored (ready=0) until the next line_start.

Source files
------------

// File: rtl/vram_write_arbiter.sv
// Two-requester round-robin arbiter feeding the even/odd scanline VRAM banks.
// State | meaning:  IDLE | no line in progress, all requests held off;  ACTIVE | render line open, arbitrating writes.
module vram_write_arbiter #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 8,
    parameter int LINE_PIXELS = 800,
    parameter int CNT_WIDTH   = $clog2(LINE_PIXELS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  line_start,
    input  logic                  render_odd,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  vram_even_we,
    output logic [ADDR_WIDTH-1:0] vram_even_addr,
    output logic [DATA_WIDTH-1:0] vram_even_d,
    output logic                  vram_odd_we,
    output logic [ADDR_WIDTH-1:0] vram_odd_addr,
    output logic [DATA_WIDTH-1:0] vram_odd_d,
    output logic [CNT_WIDTH-1:0]  write_count,
    output logic                  underrun,
    output logic                  addr_err
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t                state, state_nxt;
    logic                  bank;
    logic                  rr_last;
    logic                  grant0, grant1;
    logic                  xfer;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] xfer_addr;
    logic [DATA_WIDTH-1:0] xfer_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // rr_last=1 means req1 was granted last, so req0 wins a tie.
    always_comb begin
        state_nxt = state;
        grant0    = 1'b0;
        grant1    = 1'b0;
        case (state)
            IDLE: begin
                if (line_start) state_nxt = ACTIVE;
            end
            ACTIVE: begin
                if (!line_start) begin
                    if (req0_valid && req1_valid) begin
                        grant0 = rr_last;
                        grant1 = !rr_last;
                    end else begin
                        grant0 = req0_valid;
                        grant1 = req1_valid;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign xfer       = grant0 || grant1;
    assign xfer_addr  = grant1 ? req1_addr : req0_addr;
    assign xfer_data  = grant1 ? req1_data : req0_data;
    assign in_range   = int'(xfer_addr) < LINE_PIXELS;

    // Transfers never coincide with line_start, so the count clear and increment cannot collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank           <= 1'b0;
            rr_last        <= 1'b1;
            vram_even_we   <= 1'b0;
            vram_even_addr <= '0;
            vram_even_d    <= '0;
            vram_odd_we    <= 1'b0;
            vram_odd_addr  <= '0;
            vram_odd_d     <= '0;
            write_count    <= '0;
            underrun       <= 1'b0;
            addr_err       <= 1'b0;
        end else begin
            vram_even_we <= 1'b0;
            vram_odd_we  <= 1'b0;
            underrun     <= 1'b0;
            if (line_start) begin
                bank        <= render_odd;
                write_count <= '0;
                underrun    <= (state == ACTIVE) && (int'(write_count) < LINE_PIXELS);
            end
            if (xfer) begin
                rr_last <= grant1;
                if (in_range) begin
                    if (bank) begin
                        vram_odd_we   <= 1'b1;
                        vram_odd_addr <= xfer_addr;
                        vram_odd_d    <= xfer_data;
                    end else begin
                        vram_even_we   <= 1'b1;
                        vram_even_addr <= xfer_addr;
                        vram_even_d    <= xfer_data;
                    end
                    if (write_count != CNT_MAX) write_count <= write_count + 1'b1;
                end else begin
                    addr_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Randomized scoreboard bench for vram_write_arbiter against a line-level reference model.
module tb_vram_write_arbiter;

    localparam int AW = 10;
    localparam int DW = 8;
    localparam int LP = 800;
    localparam int CW = $clog2(LP + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          line_start = 1'b0, render_odd = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [AW-1:0] req0_addr = '0, req1_addr = '0;
    logic [DW-1:0] req0_data = '0, req1_data = '0;
    logic          vram_even_we, vram_odd_we;
    logic [AW-1:0] vram_even_addr, vram_odd_addr;
    logic [DW-1:0] vram_even_d, vram_odd_d;
    logic [CW-1:0] write_count;
    logic          underrun, addr_err;

    vram_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_PIXELS(LP)) dut (
        .clk(clk), .rst_n(rst_n), .line_start(line_start), .render_odd(render_odd),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
        .vram_even_we(vram_even_we), .vram_even_addr(vram_even_addr), .vram_even_d(vram_even_d),
        .vram_odd_we(vram_odd_we), .vram_odd_addr(vram_odd_addr), .vram_odd_d(vram_odd_d),
        .write_count(write_count), .underrun(underrun), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          odd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    // Reference model: line open flag, latched bank, last winner, pixels written this line.
    bit  m_active;
    bit  m_bank;
    int  m_last;
    int  m_count;
    bit  m_err;
    bit  m_under;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_active = 0; m_bank = 0; m_last = 1; m_count = 0; m_err = 0; m_under = 0;
        exp_q.delete();
    endfunction

    // Monitor: every write-enable must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (rst_n) begin
            if (vram_even_we || vram_odd_we) begin
                if (exp_q.size() == 0) begin
                    check("spurious_we", {vram_odd_we, vram_even_we}, 2'b00);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("we_bank", {vram_odd_we, vram_even_we}, e.odd ? 2'b10 : 2'b01);
                    check("we_addr", e.odd ? vram_odd_addr : vram_even_addr, e.addr);
                    check("we_data", e.odd ? vram_odd_d : vram_even_d, e.data);
                end
            end else if (exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                check("missing_we", {vram_odd_we, vram_even_we}, 2'b11);
            end
        end
    end

    task automatic cyc(input bit ls, input bit ro,
                       input bit v0, input int a0, input int d0,
                       input bit v1, input int a1, input int d1);
        int g;
        @(negedge clk);
        check("write_count", write_count, m_count);
        check("underrun", underrun, m_under);
        check("addr_err", addr_err, m_err);
        line_start = ls; render_odd = ro;
        req0_valid = v0; req0_addr = AW'(a0); req0_data = DW'(d0);
        req1_valid = v1; req1_addr = AW'(a1); req1_data = DW'(d1);
        g = -1;
        if (m_active && !ls) begin
            if (v0 && v1) g = (m_last == 0) ? 1 : 0;
            else if (v0)  g = 0;
            else if (v1)  g = 1;
        end
        #1;
        check("ready", {req1_ready, req0_ready}, (g == 1) ? 2'b10 : (g == 0) ? 2'b01 : 2'b00);
        @(posedge clk);
        if (g >= 0) begin
            int a;
            int d;
            a = (g == 1) ? a1 : a0;
            d = (g == 1) ? d1 : d0;
            m_last = g;
            if (a < LP) begin
                exp_q.push_back('{odd: m_bank, addr: AW'(a), data: DW'(d)});
                if (m_count < (1 << CW) - 1) m_count++;
            end else begin
                m_err = 1;
            end
        end
        m_under = ls && m_active && (m_count < LP);
        if (ls) begin
            m_bank = ro; m_count = 0; m_active = 1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_outputs",
              {vram_even_we, vram_odd_we, vram_even_addr, vram_odd_addr, vram_even_d, vram_odd_d,
               write_count, underrun, addr_err, req0_ready, req1_ready}, '0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        do_reset();
        // Requests before any line_start are held off.
        cyc(0, 0, 1, 3, 3, 1, 4, 4);

        // Full line from req0 into the even bank, then a clean line_start.
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < LP; i++) cyc(0, 0, 1, i, i & 8'hff, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check("full_line_count", write_count, LP);
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        idle(1);

        // Tie alternation after reset, odd bank.
        do_reset();
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, 10 + i, 8'h10 + i, 1, 20 + i, 8'h20 + i);

        // req1 held across a bank switch.
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 5, 8'h55);
        cyc(1, 1, 0, 0, 0, 1, 6, 8'h66);
        cyc(0, 0, 0, 0, 0, 1, 6, 8'h66);

        // Short line of 500 writes leads to an underrun pulse.
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 500; i++) cyc(0, 0, 0, 0, 0, 1, i, $urandom_range(0, 255));
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Out-of-range address is consumed, dropped and flagged stickily.
        cyc(0, 0, 1, LP, 8'hee, 0, 0, 0);
        cyc(0, 0, 1, 1023, 8'hef, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        idle(1);

        // Randomized traffic with occasional bank switches and bad addresses.
        for (int i = 0; i < 2500; i++) begin
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 1),
                $urandom_range(0, 3) != 0, $urandom_range(0, 850), $urandom_range(0, 255),
                $urandom_range(0, 2) != 0, $urandom_range(0, 850), $urandom_range(0, 255));
        end

        // Reset in the middle of a line, then requests ignored until the next line_start.
        do_reset();
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) cyc(0, 0, 1, i, i & 8'hff, 1, 799 - i, i ^ 8'h5a);
        do_reset();
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, i, i, 1, i, i);
        cyc(1, 1, 1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 100 + i, i, 1, 200 + i, i);
        idle(2);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
